// File: rtl/seq_matmul_param_if.sv
// Operand-read, result-handshake and job-control bundle for seq_matmul_param.
//   master : job owner / tile memories / result consumer
//            (drives start, a_in, b_in, z_ack)
//   slave  : the multiplier
//            (drives a_i, a_j, b_i, b_j, z_out, z_i, z_j, z_stb, done)
// Parameters must match the ones used for the multiplier instance.
interface seq_matmul_param_if #(
    parameter int unsigned M     = 4,
    parameter int unsigned K     = 4,
    parameter int unsigned P     = 4,
    parameter int unsigned W     = 32,
    parameter int unsigned OUT_W = 32
);
    localparam int unsigned MI_W = (M > 1) ? $clog2(M) : 1;
    localparam int unsigned KI_W = (K > 1) ? $clog2(K) : 1;
    localparam int unsigned PI_W = (P > 1) ? $clog2(P) : 1;

    logic             start;
    logic [W-1:0]     a_in;
    logic [W-1:0]     b_in;
    logic [MI_W-1:0]  a_i;
    logic [KI_W-1:0]  a_j;
    logic [KI_W-1:0]  b_i;
    logic [PI_W-1:0]  b_j;
    logic [OUT_W-1:0] z_out;
    logic [MI_W-1:0]  z_i;
    logic [PI_W-1:0]  z_j;
    logic             z_stb;
    logic             z_ack;
    logic             done;

    modport master (
        output start, a_in, b_in, z_ack,
        input  a_i, a_j, b_i, b_j, z_out, z_i, z_j, z_stb, done
    );

    modport slave (
        input  start, a_in, b_in, z_ack,
        output a_i, a_j, b_i, b_j, z_out, z_i, z_j, z_stb, done
    );
endinterface

// File: rtl/seq_matmul_param.sv
// Sequential M x K by K x P integer matrix multiplier.
// One A/B element pair is read per cycle through combinational-read ports;
// each Z element is emitted with its (i, j) index over a stb/ack handshake in
// row-major order, optionally saturated to OUT_W bits.
// Ports: clk, rst (async, active-low), bus (seq_matmul_param_if.slave).
module seq_matmul_param #(
    parameter int unsigned M      = 4,
    parameter int unsigned K      = 4,
    parameter int unsigned P      = 4,
    parameter int unsigned W      = 32,
    parameter int unsigned OUT_W  = 32,
    parameter int unsigned SIGNED = 1
) (
    input  logic               clk,
    input  logic               rst,
    seq_matmul_param_if.slave  bus
);
    localparam int unsigned ACC_W = 2 * W + $clog2(K);
    localparam int unsigned MI_W  = (M > 1) ? $clog2(M) : 1;
    localparam int unsigned KI_W  = (K > 1) ? $clog2(K) : 1;
    localparam int unsigned PI_W  = (P > 1) ? $clog2(P) : 1;

    // Clamp limits, only meaningful when OUT_W < ACC_W.
    localparam logic [ACC_W-1:0] SMAX = (ACC_W'(1) << (OUT_W - 1)) - ACC_W'(1);
    localparam logic [ACC_W-1:0] SMIN = ~SMAX;
    localparam logic [ACC_W-1:0] UMAX = (ACC_W'(1) << OUT_W) - ACC_W'(1);

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [MI_W-1:0]  i_q, i_d;
    logic [PI_W-1:0]  j_q, j_d;
    logic [KI_W-1:0]  k_q, k_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [MI_W-1:0]  a_i_q, a_i_d;
    logic [KI_W-1:0]  a_j_q, a_j_d;
    logic [KI_W-1:0]  b_i_q, b_i_d;
    logic [PI_W-1:0]  b_j_q, b_j_d;
    logic [OUT_W-1:0] z_out_q, z_out_d;
    logic [MI_W-1:0]  z_i_q, z_i_d;
    logic [PI_W-1:0]  z_j_q, z_j_d;
    logic             z_stb_q, z_stb_d;
    logic             done_q, done_d;

    logic [ACC_W-1:0] prod_c;
    logic [ACC_W-1:0] acc_next_c;
    logic [OUT_W-1:0] z_sat_c;
    logic             k_last_c, j_last_c, i_last_c;

    assign k_last_c = (k_q == KI_W'(K - 1));
    assign j_last_c = (j_q == PI_W'(P - 1));
    assign i_last_c = (i_q == MI_W'(M - 1));

    // Product of the current pair, extended to accumulator width.
    always_comb begin
        if (SIGNED != 0) prod_c = ACC_W'($signed(bus.a_in)) * ACC_W'($signed(bus.b_in));
        else             prod_c = ACC_W'(bus.a_in) * ACC_W'(bus.b_in);
    end

    // First term of each dot product restarts the sum.
    always_comb begin
        if (k_q == '0) acc_next_c = prod_c;
        else           acc_next_c = acc_q + prod_c;
    end

    // Extend or clamp the finished sum to the result width.
    always_comb begin
        z_sat_c = '0;
        if (OUT_W >= ACC_W) begin
            if (SIGNED != 0) z_sat_c = OUT_W'($signed(acc_next_c));
            else             z_sat_c = OUT_W'(acc_next_c);
        end else if (SIGNED != 0) begin
            if ($signed(acc_next_c) > $signed(SMAX))      z_sat_c = OUT_W'(SMAX);
            else if ($signed(acc_next_c) < $signed(SMIN)) z_sat_c = OUT_W'(SMIN);
            else                                          z_sat_c = OUT_W'(acc_next_c);
        end else begin
            if (acc_next_c > UMAX) z_sat_c = OUT_W'(UMAX);
            else                   z_sat_c = OUT_W'(acc_next_c);
        end
    end

    // State register and all datapath/output flops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            acc_q   <= '0;
            a_i_q   <= '0;
            a_j_q   <= '0;
            b_i_q   <= '0;
            b_j_q   <= '0;
            z_out_q <= '0;
            z_i_q   <= '0;
            z_j_q   <= '0;
            z_stb_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
            a_i_q   <= a_i_d;
            a_j_q   <= a_j_d;
            b_i_q   <= b_i_d;
            b_j_q   <= b_j_d;
            z_out_q <= z_out_d;
            z_i_q   <= z_i_d;
            z_j_q   <= z_j_d;
            z_stb_q <= z_stb_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (bus.start) state_d = S_MAC;
            S_MAC:  if (k_last_c) state_d = S_OUT;
            S_OUT:  if (bus.z_ack) state_d = (j_last_c && i_last_c) ? S_DONE : S_MAC;
            S_DONE: if (!bus.start) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Counters, accumulator and registered outputs.
    always_comb begin
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        acc_d   = acc_q;
        z_out_d = z_out_q;
        z_i_d   = z_i_q;
        z_j_d   = z_j_q;
        z_stb_d = z_stb_q;
        done_d  = done_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    i_d   = '0;
                    j_d   = '0;
                    k_d   = '0;
                    acc_d = '0;
                end
            end
            S_MAC: begin
                acc_d = acc_next_c;
                if (k_last_c) begin
                    z_out_d = z_sat_c;
                    z_i_d   = i_q;
                    z_j_d   = j_q;
                    z_stb_d = 1'b1;
                end else begin
                    k_d = k_q + KI_W'(1);
                end
            end
            S_OUT: begin
                if (bus.z_ack) begin
                    z_stb_d = 1'b0;
                    k_d     = '0;
                    if (!j_last_c) begin
                        j_d = j_q + PI_W'(1);
                    end else if (!i_last_c) begin
                        i_d = i_q + MI_W'(1);
                        j_d = '0;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_DONE: if (!bus.start) done_d = 1'b0;
            default: ;
        endcase

        // Addresses are registered so they are valid for the whole MAC cycle.
        a_i_d = '0;
        a_j_d = '0;
        b_i_d = '0;
        b_j_d = '0;
        if (state_d == S_MAC) begin
            a_i_d = i_d;
            a_j_d = k_d;
            b_i_d = k_d;
            b_j_d = j_d;
        end
    end

    assign bus.a_i   = a_i_q;
    assign bus.a_j   = a_j_q;
    assign bus.b_i   = b_i_q;
    assign bus.b_j   = b_j_q;
    assign bus.z_out = z_out_q;
    assign bus.z_i   = z_i_q;
    assign bus.z_j   = z_j_q;
    assign bus.z_stb = z_stb_q;
    assign bus.done  = done_q;
endmodule

// File: tb/tb_seq_matmul_param.sv
// Directed bench for seq_matmul_param across four parameter sets:
//   dut0 2x2x2 signed 32b, dut1 defaults, dut2 2x3x4 unsigned 8b,
//   dut3 2x2x1 signed 8b saturating to 8b.
module tb_seq_matmul_param;
    logic clk;
    logic rst;
    logic start0, start1, start2, start3;
    logic ack0, ack1, ack2, ack3;
    int   ack_mode0;
    int   n_checks, n_errors;
    int   cyc;
    int   bp_cnt0;
    logic pulse0;
    logic stb_prev0, ack_prev0, stb_smp0;
    logic [47:0] held0, cur0;
    logic [47:0] q0[$], q1[$], q2[$], q3[$];
    logic [47:0] exp0 [4];
    logic [31:0] a0 [2][2];
    logic [31:0] b0 [2][2];
    logic [7:0]  a3 [2][2];
    logic [3:0]  done_w;
    logic        found;

    seq_matmul_param_if #(.M(2), .K(2), .P(2), .W(32), .OUT_W(32)) if0 ();
    seq_matmul_param_if #(.M(4), .K(4), .P(4), .W(32), .OUT_W(32)) if1 ();
    seq_matmul_param_if #(.M(2), .K(3), .P(4), .W(8),  .OUT_W(32)) if2 ();
    seq_matmul_param_if #(.M(2), .K(2), .P(1), .W(8),  .OUT_W(8))  if3 ();

    seq_matmul_param #(.M(2), .K(2), .P(2), .W(32), .OUT_W(32), .SIGNED(1))
        dut0 (.clk(clk), .rst(rst), .bus(if0));
    seq_matmul_param #(.M(4), .K(4), .P(4), .W(32), .OUT_W(32), .SIGNED(1))
        dut1 (.clk(clk), .rst(rst), .bus(if1));
    seq_matmul_param #(.M(2), .K(3), .P(4), .W(8), .OUT_W(32), .SIGNED(0))
        dut2 (.clk(clk), .rst(rst), .bus(if2));
    seq_matmul_param #(.M(2), .K(2), .P(1), .W(8), .OUT_W(8), .SIGNED(1))
        dut3 (.clk(clk), .rst(rst), .bus(if3));

    // Tile memories and control.
    assign if0.start = start0;
    assign if0.z_ack = ack0;
    assign if0.a_in  = a0[if0.a_i][if0.a_j];
    assign if0.b_in  = b0[if0.b_i][if0.b_j];

    assign if1.start = start1;
    assign if1.z_ack = ack1;
    assign if1.a_in  = (if1.a_i == if1.a_j) ? 32'd1 : 32'd0;
    assign if1.b_in  = 32'({if1.b_i, if1.b_j});

    assign if2.start = start2;
    assign if2.z_ack = ack2;
    assign if2.a_in  = 8'hFF;
    assign if2.b_in  = 8'hFF;

    assign if3.start = start3;
    assign if3.z_ack = ack3;
    assign if3.a_in  = a3[if3.a_i][if3.a_j];
    assign if3.b_in  = 8'h80;

    assign done_w = {if3.done, if2.done, if1.done, if0.done};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_done(input int idx, input int budget, output int cycles);
        cycles = 0;
        while (cycles < budget && !done_w[idx]) begin
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    // dut0 acknowledge: 0 = tied high, 1 = registered echo of z_stb,
    // 2 = 7 cycles of backpressure per strobe with toggling ack while idle.
    always @(posedge clk) begin
        #1;
        if (ack_mode0 == 1) begin
            ack0 = stb_smp0;
        end else if (ack_mode0 == 2) begin
            if (if0.z_stb) begin
                bp_cnt0++;
                ack0 = (bp_cnt0 > 7);
            end else begin
                bp_cnt0 = 0;
                pulse0  = ~pulse0;
                ack0    = pulse0;
            end
        end else begin
            ack0 = 1'b1;
        end
    end

    // Result monitors: a transfer is z_stb && z_ack just before a rising edge.
    always @(negedge clk) begin
        cur0 = {8'(if0.z_i), 8'(if0.z_j), if0.z_out};
        if (if0.z_stb && stb_prev0 && !ack_prev0)
            check_eq("hold0", 64'(cur0), 64'(held0));
        if (if0.z_stb && if0.z_ack) q0.push_back(cur0);
        held0     = cur0;
        stb_prev0 = if0.z_stb;
        ack_prev0 = if0.z_ack;
        stb_smp0  = if0.z_stb;
    end

    always @(negedge clk) begin
        if (if1.z_stb && if1.z_ack) q1.push_back({8'(if1.z_i), 8'(if1.z_j), if1.z_out});
        if (if2.z_stb && if2.z_ack) q2.push_back({8'(if2.z_i), 8'(if2.z_j), if2.z_out});
        if (if3.z_stb && if3.z_ack)
            q3.push_back({8'(if3.z_i), 8'(if3.z_j), 32'($signed(if3.z_out))});
    end

    initial begin
        rst = 1'b0;
        start0 = 1'b0; start1 = 1'b0; start2 = 1'b0; start3 = 1'b0;
        ack0 = 1'b0; ack1 = 1'b1; ack2 = 1'b1; ack3 = 1'b1;
        ack_mode0 = 1;
        n_checks = 0; n_errors = 0;
        bp_cnt0 = 0; pulse0 = 1'b0;
        stb_prev0 = 1'b0; ack_prev0 = 1'b0; stb_smp0 = 1'b0;
        held0 = '0; cur0 = '0;
        a0[0][0] = 32'd1; a0[0][1] = 32'd2; a0[1][0] = 32'd3; a0[1][1] = 32'd4;
        b0[0][0] = 32'd5; b0[0][1] = 32'd6; b0[1][0] = 32'd7; b0[1][1] = 32'd8;
        a3[0][0] = 8'h80; a3[0][1] = 8'h80; a3[1][0] = 8'h7F; a3[1][1] = 8'h7F;
        exp0[0] = {8'd0, 8'd0, 32'd19};
        exp0[1] = {8'd0, 8'd1, 32'd22};
        exp0[2] = {8'd1, 8'd0, 32'd43};
        exp0[3] = {8'd1, 8'd1, 32'd50};

        // Reset state.
        repeat (3) @(negedge clk);
        check_eq("rst_stb",  64'(if1.z_stb), 64'd0);
        check_eq("rst_done", 64'(if1.done),  64'd0);
        check_eq("rst_zout", 64'(if1.z_out), 64'd0);
        check_eq("rst_addr", 64'({if1.a_i, if1.a_j, if1.b_i, if1.b_j}), 64'd0);
        rst = 1'b1;

        // 2x2 signed with registered-echo ack.
        @(posedge clk); #1;
        start0 = 1'b1;
        wait_done(0, 100, cyc);
        check_eq("t1_done", 64'(done_w[0]), 64'd1);
        check_eq("t1_count", 64'(q0.size()), 64'd4);
        for (int n = 0; n < 4; n++)
            check_eq("t1_z", 64'((n < q0.size()) ? q0[n] : '1), 64'(exp0[n]));
        repeat (3) @(posedge clk);
        #1;
        check_eq("t1_done_hold", 64'(done_w[0]), 64'd1);
        start0 = 1'b0;
        @(posedge clk); #1;
        check_eq("t1_done_clr", 64'(done_w[0]), 64'd0);

        // Defaults: identity x B, ack tied high, timed job.
        @(posedge clk); #1;
        start1 = 1'b1;
        wait_done(1, 200, cyc);
        check_eq("t2_cycles", 64'(cyc), 64'd81);
        check_eq("t2_count", 64'(q1.size()), 64'd16);
        for (int n = 0; n < 16; n++)
            check_eq("t2_z", 64'((n < q1.size()) ? q1[n] : '1),
                     64'({8'(n / 4), 8'(n % 4), 32'(n)}));
        start1 = 1'b0;
        @(posedge clk); #1;

        // Unsigned 8-bit full-scale operands.
        start2 = 1'b1;
        wait_done(2, 200, cyc);
        check_eq("t3_done", 64'(done_w[2]), 64'd1);
        check_eq("t3_count", 64'(q2.size()), 64'd8);
        for (int n = 0; n < 8; n++)
            check_eq("t3_z", 64'((n < q2.size()) ? q2[n] : '1),
                     64'({8'(n / 4), 8'(n % 4), 32'd195075}));
        start2 = 1'b0;
        @(posedge clk); #1;

        // Signed saturation to 8 bits.
        start3 = 1'b1;
        wait_done(3, 100, cyc);
        check_eq("t4_done", 64'(done_w[3]), 64'd1);
        check_eq("t4_count", 64'(q3.size()), 64'd2);
        check_eq("t4_pos_sat", 64'((q3.size() > 0) ? q3[0] : '1), 64'({8'd0, 8'd0, 32'h0000_007F}));
        check_eq("t4_neg_sat", 64'((q3.size() > 1) ? q3[1] : '1), 64'({8'd1, 8'd0, 32'hFFFF_FF80}));
        start3 = 1'b0;
        @(posedge clk); #1;

        // Backpressure with spurious acks while z_stb is low.
        ack_mode0 = 2;
        q0.delete();
        @(posedge clk); #1;
        start0 = 1'b1;
        wait_done(0, 400, cyc);
        check_eq("t5_cycles", 64'(cyc), 64'd41);
        check_eq("t5_count", 64'(q0.size()), 64'd4);
        for (int n = 0; n < 4; n++)
            check_eq("t5_z", 64'((n < q0.size()) ? q0[n] : '1), 64'(exp0[n]));
        start0 = 1'b0;
        ack_mode0 = 0;
        @(posedge clk); #1;

        // Asynchronous reset in the middle of element (1,2), then restart.
        q1.delete();
        start1 = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 200 && !found; c++) begin
            @(negedge clk);
            if (if1.a_i == 2'd1 && if1.b_j == 2'd2 && if1.a_j == 2'd2) found = 1'b1;
        end
        check_eq("t6_found", 64'(found), 64'd1);
        rst = 1'b0;
        #1;
        check_eq("t6_rst_stb",  64'(if1.z_stb), 64'd0);
        check_eq("t6_rst_done", 64'(if1.done),  64'd0);
        check_eq("t6_rst_zout", 64'(if1.z_out), 64'd0);
        check_eq("t6_rst_idx",  64'({if1.z_i, if1.z_j}), 64'd0);
        check_eq("t6_rst_addr", 64'({if1.a_i, if1.a_j, if1.b_i, if1.b_j}), 64'd0);
        q1.delete();
        @(negedge clk);
        check_eq("t6_rst_hold", 64'(if1.z_stb), 64'd0);
        rst = 1'b1;
        wait_done(1, 200, cyc);
        check_eq("t6_cycles", 64'(cyc), 64'd81);
        check_eq("t6_count", 64'(q1.size()), 64'd16);
        for (int n = 0; n < 16; n++)
            check_eq("t6_z", 64'((n < q1.size()) ? q1[n] : '1),
                     64'({8'(n / 4), 8'(n % 4), 32'(n)}));
        start1 = 1'b0;
        repeat (2) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
